serial_add_ctrl: RTL and testbench
==================================

# serial_add_ctrl

Bit-serial adder controller that sequences a single instance of the team's one-bit full adder over WIDTH-bit operands, one bit per clock, LSB first. It accepts an operand pair over a valid/ready request handshake and registers the carry between bit steps. It returns the WIDTH-bit sum and carry-out over a valid/ready result handshake. It sits between an operand producer and a result consumer, and trades latency for area against a ripple-carry array.

## Interface
- WIDTH, 8, operand/sum width in bits; legal range 1..32
- clk_i  input  1  clock; all state updates on rising edge
- rst_ni  input  1  synchronous, active-low reset
- req_valid_i  input  1  operand pair and carry-in are valid
- req_ready_o  output  1  controller can accept an operand pair
- a_i  input  WIDTH  operand A
- b_i  input  WIDTH  operand B
- cin_i  input  1  carry-in to bit 0
- res_valid_o  output  1  sum_o/cout_o hold a completed result
- res_ready_i  input  1  consumer accepts the result
- sum_o  output  WIDTH  A + B + cin, low WIDTH bits
- cout_o  output  1  carry out of bit WIDTH-1
- busy_o  output  1  high in RUN or DONE

## Operation
- States: IDLE, RUN, DONE. The state register resets to IDLE.
- IDLE:
  - req_ready_o=1.
  - On req_valid_i&&req_ready_o: latch a_i and b_i into shift registers, load the carry register with cin_i, clear the bit counter, clear the sum register, go to RUN.
- RUN, one bit per cycle:
  - The full adder sees a_sh[0], b_sh[0] and the carry register.
  - Each edge: shift a_sh and b_sh right by 1. Shift the FA sum into the sum register from the MSB end (sum_sh <= {fa_sum, sum_sh[WIDTH-1:1]}). Load the carry register with the FA carry. Increment the counter.
  - When counter==WIDTH-1 at an edge, that edge completes the last bit and the next state is DONE.
- DONE:
  - res_valid_o=1. sum_o=sum register, cout_o=carry register.
  - On res_valid_o&&res_ready_i, go to IDLE.
- Outputs are stable while in DONE. sum_o/cout_o keep their last value in IDLE and are only overwritten by the next accept (sum clear) and RUN shifts.
- req_valid_i in RUN or DONE is ignored; req_ready_o=0 there. There is no accept in the same cycle as a result handoff. Throughput is one operation per WIDTH+2 cycles minimum.
- Counter width is max(1,$clog2(WIDTH)). It must not wrap before the terminal compare. For WIDTH=1, RUN lasts exactly one cycle.
- Arithmetic: {cout_o,sum_o} equals a+b+cin modulo 2^(WIDTH+1), i.e. exact.

## Timing
- Reset values: req_ready_o=1 (IDLE), res_valid_o=0, sum_o=0, cout_o=0, busy_o=0. All internal shift registers, the counter and the carry register are 0.
- Reset takes effect at the first rising edge with rst_ni=0, from any state. Mid-RUN or in DONE, the operation is discarded with no result ever presented. The state is IDLE and outputs hold their reset values on the cycle after that edge.
- Latency: accept at edge E0. Bits are processed at edges E1..EWIDTH. res_valid_o goes high in the cycle after edge EWIDTH, i.e. WIDTH cycles after the accept edge.
- Handshakes are sampled at rising edges. res_valid_o is not dependent on res_ready_i combinationally. It stays high until the handshake edge, then drops on the next cycle.
- req_ready_o and busy_o are decoded from the state register only; there is no combinational path from any input.

## Test plan
- Basic add, WIDTH=8: a=0x5A, b=0x3C, cin=0 -> sum_o=0x96, cout_o=0. res_valid_o rises exactly 8 cycles after the accept edge; busy_o is high throughout.
- Carry propagation, WIDTH=8:
  - 0xFF+0x01, cin=0 -> sum_o=0x00, cout_o=1.
  - 0xFF+0xFF, cin=1 -> sum_o=0xFF, cout_o=1.
  - 0x00+0x00, cin=1 -> sum_o=0x01, cout_o=0.
- Backpressure:
  - Hold res_ready_i=0 for 5 cycles after res_valid_o rises -> sum_o/cout_o/res_valid_o stay constant, req_ready_o=0.
  - Toggle req_valid_i with new operands during RUN and DONE -> no effect on the result. The new pair is accepted only in IDLE.
- Reset mid-operation: assert rst_ni=0 for one edge after 3 RUN bits of 0x5A+0x3C -> the next cycle shows IDLE, req_ready_o=1, res_valid_o=0, sum_o=0. A following 0x01+0x02 returns 0x03 normally.
- Back-to-back and WIDTH=1:
  - WIDTH=8: two requests held valid continuously with res_ready_i=1 -> the accepts are WIDTH+2=10 cycles apart, and both results are correct.
  - WIDTH=1: 1+1, cin=1 -> sum_o=1, cout_o=1, with res_valid_o one cycle after accept.

Source files
------------

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full adder walks WIDTH-bit operands LSB first, one bit per clock.
// Result valid WIDTH cycles after accept; result held until res_ready_i, no accept while busy.
module full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_s,
  output logic o_c
);
  assign o_s = i_a ^ i_b ^ i_c;
  assign o_c = (i_a & i_b) | (i_c & (i_a ^ i_b));
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             busy_o
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_sum_sh;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic             w_fa_sum;
  logic             w_fa_carry;
  logic [WIDTH-1:0] w_sum_nxt;
  logic             w_last_bit;

  full_adder u_fa (
    .i_a (r_a_sh[0]),
    .i_b (r_b_sh[0]),
    .i_c (r_carry),
    .o_s (w_fa_sum),
    .o_c (w_fa_carry)
  );

  // A one-bit sum register has no upper bits to shift down.
  generate
    if (WIDTH == 1) begin : g_sum_w1
      assign w_sum_nxt = w_fa_sum;
    end else begin : g_sum_wn
      assign w_sum_nxt = {w_fa_sum, r_sum_sh[WIDTH-1:1]};
    end
  endgenerate

  assign w_last_bit = (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    req_ready_o = 1'b0;
    res_valid_o = 1'b0;
    busy_o      = 1'b1;
    case (r_state)
      S_IDLE: begin
        req_ready_o = 1'b1;
        busy_o      = 1'b0;
        if (req_valid_i) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (w_last_bit) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        res_valid_o = 1'b1;
        if (res_ready_i) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_sum_sh <= '0;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
    end else if (r_state == S_IDLE) begin
      if (req_valid_i) begin
        r_a_sh   <= a_i;
        r_b_sh   <= b_i;
        r_sum_sh <= '0;
        r_carry  <= cin_i;
        r_cnt    <= '0;
      end
    end else if (r_state == S_RUN) begin
      r_a_sh   <= r_a_sh >> 1;
      r_b_sh   <= r_b_sh >> 1;
      r_sum_sh <= w_sum_nxt;
      r_carry  <= w_fa_carry;
      r_cnt    <= r_cnt + CW'(1);
    end
  end

  assign sum_o  = r_sum_sh;
  assign cout_o = r_carry;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl: an 8-bit instance for most scenarios, a 1-bit instance for the degenerate width.
module tb_serial_add_ctrl;
  logic       clk;
  logic       rst_n;
  logic       req_valid, req_ready, res_valid, res_ready, cin, cout, busy;
  logic [7:0] a, b, sum;
  logic       w1_req_valid, w1_req_ready, w1_res_valid, w1_res_ready;
  logic       w1_cin, w1_cout, w1_busy;
  logic [0:0] w1_a, w1_b, w1_sum;

  int n_tests = 0;
  int n_fail  = 0;

  serial_add_ctrl #(.WIDTH(8)) dut8 (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .a_i(a), .b_i(b), .cin_i(cin),
    .res_valid_o(res_valid), .res_ready_i(res_ready),
    .sum_o(sum), .cout_o(cout), .busy_o(busy)
  );

  serial_add_ctrl #(.WIDTH(1)) dut1 (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(w1_req_valid), .req_ready_o(w1_req_ready),
    .a_i(w1_a), .b_i(w1_b), .cin_i(w1_cin),
    .res_valid_o(w1_res_valid), .res_ready_i(w1_res_ready),
    .sum_o(w1_sum), .cout_o(w1_cout), .busy_o(w1_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_accept(input logic [7:0] ia, input logic [7:0] ib, input logic ic);
    a = ia; b = ib; cin = ic; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_res(output int cyc);
    cyc = 0;
    while (!res_valid && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic handoff();
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
    n_tests++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL reset_res_valid got %b want 0", res_valid); end
    n_tests++; if (sum !== 8'h00) begin n_fail++; $display("FAIL reset_sum got %h want 00", sum); end
    n_tests++; if (cout !== 1'b0) begin n_fail++; $display("FAIL reset_cout got %b want 0", cout); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_tests++; if (w1_req_ready !== 1'b1 || w1_res_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_w1 got ready=%b valid=%b want 1/0", w1_req_ready, w1_res_valid);
    end
  endtask

  task automatic test_basic();
    int cyc;
    int busy_low;
    do_accept(8'h5A, 8'h3C, 1'b0);
    cyc = 0; busy_low = 0;
    while (!res_valid && cyc < 50) begin
      if (busy !== 1'b1) busy_low++;
      @(posedge clk); #1;
      cyc++;
    end
    if (busy !== 1'b1) busy_low++;
    n_tests++; if (cyc !== 8) begin n_fail++; $display("FAIL basic_latency got %0d want 8", cyc); end
    n_tests++; if (busy_low !== 0) begin n_fail++; $display("FAIL basic_busy low_cycles got %0d want 0", busy_low); end
    n_tests++; if (sum !== 8'h96) begin n_fail++; $display("FAIL basic_sum got %h want 96", sum); end
    n_tests++; if (cout !== 1'b0) begin n_fail++; $display("FAIL basic_cout got %b want 0", cout); end
    handoff();
    n_tests++; if (res_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++; $display("FAIL basic_release got valid=%b ready=%b want 0/1", res_valid, req_ready);
    end
  endtask

  task automatic test_carry();
    logic [7:0] va [3] = '{8'hFF, 8'hFF, 8'h00};
    logic [7:0] vb [3] = '{8'h01, 8'hFF, 8'h00};
    logic       vc [3] = '{1'b0, 1'b1, 1'b1};
    logic [7:0] es [3] = '{8'h00, 8'hFF, 8'h01};
    logic       ec [3] = '{1'b1, 1'b1, 1'b0};
    int cyc;
    for (int i = 0; i < 3; i++) begin
      do_accept(va[i], vb[i], vc[i]);
      wait_res(cyc);
      n_tests++; if (cyc !== 8 || sum !== es[i] || cout !== ec[i]) begin
        n_fail++;
        $display("FAIL carry_%0d got cyc=%0d sum=%h cout=%b want cyc=8 sum=%h cout=%b", i, cyc, sum, cout, es[i], ec[i]);
      end
      handoff();
    end
  endtask

  task automatic test_backpressure();
    int cyc;
    int bad;
    do_accept(8'h12, 8'h34, 1'b1);
    cyc = 0;
    while (!res_valid && cyc < 50) begin
      req_valid = cyc[0]; a = 8'hAA; b = 8'h55; cin = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
    n_tests++; if (cyc !== 8) begin n_fail++; $display("FAIL bp_latency got %0d want 8", cyc); end
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (sum !== 8'h47 || cout !== 1'b0 || res_valid !== 1'b1 || req_ready !== 1'b0) bad++;
      req_valid = ~req_valid;
      @(posedge clk); #1;
    end
    n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL bp_hold bad_cycles got %0d want 0", bad); end
    n_tests++; if (sum !== 8'h47 || cout !== 1'b0) begin
      n_fail++; $display("FAIL bp_result got sum=%h cout=%b want 47/0", sum, cout);
    end
    // Request held through the handoff edge must not be taken on that edge.
    req_valid = 1'b1; a = 8'hAA; b = 8'h55; cin = 1'b0;
    handoff();
    n_tests++; if (busy !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_no_same_cycle_accept got busy=%b ready=%b want 0/1", busy, req_ready);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_res(cyc);
    n_tests++; if (cyc !== 8 || sum !== 8'hFF || cout !== 1'b0) begin
      n_fail++; $display("FAIL bp_next_op got cyc=%0d sum=%h cout=%b want 8/FF/0", cyc, sum, cout);
    end
    handoff();
  endtask

  task automatic test_reset_mid();
    int cyc;
    do_accept(8'h5A, 8'h3C, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    n_tests++; if (req_ready !== 1'b1 || res_valid !== 1'b0 || sum !== 8'h00 || busy !== 1'b0 || cout !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset got ready=%b valid=%b sum=%h busy=%b cout=%b want 1/0/00/0/0", req_ready, res_valid, sum, busy, cout);
    end
    do_accept(8'h01, 8'h02, 1'b0);
    wait_res(cyc);
    n_tests++; if (cyc !== 8 || sum !== 8'h03 || cout !== 1'b0) begin
      n_fail++; $display("FAIL midreset_after got cyc=%0d sum=%h cout=%b want 8/03/0", cyc, sum, cout);
    end
    handoff();
  endtask

  task automatic test_back_to_back();
    int t, n_acc, n_res;
    int acc_t [2];
    logic [7:0] rs [2];
    logic       rc [2];
    logic       will_acc;
    t = 0; n_acc = 0; n_res = 0;
    a = 8'h10; b = 8'h20; cin = 1'b0; req_valid = 1'b1; res_ready = 1'b1;
    while (n_res < 2 && t < 60) begin
      will_acc = req_ready && req_valid;
      @(posedge clk); #1;
      t++;
      if (will_acc) begin
        acc_t[n_acc] = t;
        n_acc++;
        if (n_acc == 1) begin a = 8'hC8; b = 8'h64; cin = 1'b1; end
        else req_valid = 1'b0;
      end
      if (res_valid) begin
        rs[n_res] = sum; rc[n_res] = cout;
        n_res++;
      end
    end
    req_valid = 1'b0; res_ready = 1'b0;
    n_tests++; if (n_acc !== 2 || n_res !== 2) begin
      n_fail++; $display("FAIL b2b_counts got acc=%0d res=%0d want 2/2", n_acc, n_res);
    end else begin
      n_tests++; if (acc_t[1] - acc_t[0] !== 10) begin
        n_fail++; $display("FAIL b2b_spacing got %0d want 10", acc_t[1] - acc_t[0]);
      end
      n_tests++; if (rs[0] !== 8'h30 || rc[0] !== 1'b0) begin
        n_fail++; $display("FAIL b2b_res0 got %h/%b want 30/0", rs[0], rc[0]);
      end
      n_tests++; if (rs[1] !== 8'h2D || rc[1] !== 1'b1) begin
        n_fail++; $display("FAIL b2b_res1 got %h/%b want 2D/1", rs[1], rc[1]);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_width1();
    int cyc;
    w1_a = 1'b1; w1_b = 1'b1; w1_cin = 1'b1; w1_req_valid = 1'b1;
    @(posedge clk); #1;
    w1_req_valid = 1'b0;
    cyc = 0;
    while (!w1_res_valid && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    n_tests++; if (cyc !== 1) begin n_fail++; $display("FAIL w1_latency got %0d want 1", cyc); end
    n_tests++; if (w1_sum !== 1'b1 || w1_cout !== 1'b1) begin
      n_fail++; $display("FAIL w1_result got sum=%b cout=%b want 1/1", w1_sum, w1_cout);
    end
    w1_res_ready = 1'b1;
    @(posedge clk); #1;
    w1_res_ready = 1'b0;
    n_tests++; if (w1_res_valid !== 1'b0 || w1_req_ready !== 1'b1) begin
      n_fail++; $display("FAIL w1_release got valid=%b ready=%b want 0/1", w1_res_valid, w1_req_ready);
    end
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; res_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
    w1_req_valid = 1'b0; w1_res_ready = 1'b0; w1_a = '0; w1_b = '0; w1_cin = 1'b0;
    test_reset();
    test_basic();
    test_carry();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_width1();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
